// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Owner encoding for the pending read and the last-grant encoding used by the picker.
package mem_arb_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_t;

  typedef enum logic {
    GRANT_INSTR = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_t;

  // Bit positions in the one-hot grant vector returned by mem_arb_pick.
  localparam int GNT_I = 0;
  localparam int GNT_D = 1;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between the fetch and data requesters; one-hot grant out.
// MEM_ARB_ROUND_ROBIN_EN selects alternating priority, otherwise data always wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  grant_t     last_grant,
  output logic [1:0] grant
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    grant = 2'b00;
    if (i_req && d_req) begin
      // Contention goes to whichever port did not win most recently.
      if (last_grant == GRANT_INSTR) grant[GNT_D] = 1'b1;
      else                           grant[GNT_I] = 1'b1;
    end else begin
      grant[GNT_I] = i_req;
      grant[GNT_D] = d_req;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = (last_grant == GRANT_DATA);

  always_comb begin
    grant        = 2'b00;
    grant[GNT_D] = d_req;
    grant[GNT_I] = i_req & ~d_req;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for an instruction-fetch port and a data load/store port.
// Optional MEM_ARB_ROUND_ROBIN_EN enables round-robin contention; default is data-first.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [31:0]           i_rdata,

  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  input  logic [3:0]            d_wmask,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [31:0]           d_rdata,

  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic                  mem_rstrb,
  input  logic [31:0]           mem_rdata,

  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wmask
);

  logic [1:0] pick;
  grant_t     last_grant;
  owner_t     owner, owner_next;
  logic       d_read, d_write;

  mem_arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .grant      (pick)
  );

  // Grants are masked during reset so nothing reaches memory while it is held.
  assign i_gnt   = pick[GNT_I] & ~reset;
  assign d_gnt   = pick[GNT_D] & ~reset;
  assign d_read  = d_gnt & ~d_we;
  assign d_write = d_gnt & d_we;

  assign mem_rstrb = i_gnt | d_read;
  assign mem_raddr = d_read ? d_addr : i_addr;
  assign mem_waddr = d_addr;
  assign mem_wdata = d_wdata;
  assign mem_wmask = d_write ? d_wmask : 4'b0000;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    owner_next = OWN_NONE;
    if (i_gnt)       owner_next = OWN_INSTR;
    else if (d_read) owner_next = OWN_DATA;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) owner <= OWN_NONE;
    else       owner <= owner_next;
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (reset)              last_grant <= GRANT_INSTR;
    else if (i_gnt | d_gnt) last_grant <= d_gnt ? GRANT_DATA : GRANT_INSTR;
  end
`else
  assign last_grant = GRANT_INSTR;
`endif

  // A read in flight when reset rises is dropped rather than returned.
  assign i_rvalid = (owner == OWN_INSTR) & ~reset;
  assign d_rvalid = (owner == OWN_DATA)  & ~reset;
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a memory responder, a per-cycle reference
// model with its own memory image, and directed scenarios with literal expectations.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wmask;
  logic [31:0] mem_raddr, mem_waddr, mem_wdata;
  logic        mem_rstrb;
  logic [31:0] mem_rdata = 32'h0;
  logic [3:0]  mem_wmask;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wmask   (d_wmask),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_raddr (mem_raddr),
    .mem_rstrb (mem_rstrb),
    .mem_rdata (mem_rdata),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask)
  );

  function automatic logic [31:0] init_word(int k);
    return 32'h1000_0000 + k;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Memory responder: driven only by the DUT's memory ports.
  logic [31:0] sim_mem [256];
  bit          sim_loaded = 1'b0;
  always @(posedge clk) begin
    if (!sim_loaded) begin
      for (int k = 0; k < 256; k++) sim_mem[k] <= init_word(k);
      sim_loaded <= 1'b1;
    end else begin
      if (mem_rstrb) mem_rdata <= sim_mem[mem_raddr[9:2]];
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) sim_mem[mem_waddr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // Reference model: decides grants from the arbitration rules, keeps its own memory image.
  logic [31:0] ref_mem [256];
  bit          ref_loaded = 1'b0;
  bit          pend_i = 1'b0, pend_d = 1'b0, last_was_d = 1'b0;
  logic [31:0] pend_data = 32'h0;

  always @(negedge clk) begin
    logic ei, ed, erd, ewr;
    ei = 1'b0;
    ed = 1'b0;
    if (!reset) begin
      if (i_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (last_was_d) ei = 1'b1;
        else            ed = 1'b1;
`else
        ed = 1'b1;
`endif
      end else begin
        ei = i_req;
        ed = d_req;
      end
    end
    erd = ed && !d_we;
    ewr = ed && d_we;

    check("i_gnt", i_gnt, ei);
    check("d_gnt", d_gnt, ed);
    check("mem_rstrb", mem_rstrb, ei || erd);
    if (ei)  check("mem_raddr_i", mem_raddr, i_addr);
    if (erd) check("mem_raddr_d", mem_raddr, d_addr);
    check("mem_wmask", mem_wmask, ewr ? d_wmask : 4'b0000);
    if (ewr) begin
      check("mem_waddr", mem_waddr, d_addr);
      check("mem_wdata", mem_wdata, d_wdata);
    end
    check("i_rvalid", i_rvalid, !reset && pend_i);
    check("d_rvalid", d_rvalid, !reset && pend_d);
    if (!reset && pend_i) check("i_rdata", i_rdata, pend_data);
    if (!reset && pend_d) check("d_rdata", d_rdata, pend_data);

    if (!ref_loaded) begin
      for (int k = 0; k < 256; k++) ref_mem[k] <= init_word(k);
      ref_loaded <= 1'b1;
    end
    if (reset) begin
      pend_i     <= 1'b0;
      pend_d     <= 1'b0;
      last_was_d <= 1'b0;
    end else begin
      pend_i <= ei;
      pend_d <= erd;
      if (ei)  pend_data <= ref_mem[i_addr[9:2]];
      if (erd) pend_data <= ref_mem[d_addr[9:2]];
      if (ewr)
        for (int b = 0; b < 4; b++)
          if (d_wmask[b]) ref_mem[d_addr[9:2]][8*b +: 8] <= d_wdata[8*b +: 8];
      if (ei || ed) last_was_d <= ed;
    end
  end

  task automatic drive(bit ir, logic [31:0] ia, bit dr, bit we, logic [31:0] da,
                       logic [31:0] wd, logic [3:0] wm);
    i_req   = ir;
    i_addr  = ia;
    d_req   = dr;
    d_we    = we;
    d_addr  = da;
    d_wdata = wd;
    d_wmask = wm;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] g_log;

  initial begin
    reset = 1'b1;
    drive(1'b1, 32'h4, 1'b1, 1'b0, 32'h190, 32'h0, 4'h0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("reset_i_gnt", i_gnt, 1'b0);
    check("reset_d_gnt", d_gnt, 1'b0);
    check("reset_rstrb", mem_rstrb, 1'b0);
    next_cycle();
    reset = 1'b0;
    idle();
    next_cycle();

    // Single fetch of 0x8.
    drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("fetch_gnt", i_gnt, 1'b1);
    check("fetch_raddr", mem_raddr, 32'h8);
    next_cycle();
    idle();
    @(negedge clk);
    check("fetch_rvalid", i_rvalid, 1'b1);
    check("fetch_rdata", i_rdata, 32'h1000_0002);
    next_cycle();

    // Load/fetch contention held for three cycles.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h4, 1'b1, 1'b0, 32'h190, 32'h0, 4'h0);
      @(negedge clk);
      g_log[2-k] = d_gnt;
      next_cycle();
    end
    idle();
    @(negedge clk);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    check("contention_seq", g_log, 3'b101);
`else
    check("contention_seq", g_log, 3'b111);
`endif
    check("contention_last_rdata", d_rdata, 32'h1000_0064);
    next_cycle();

    // Byte-masked store, then reload.
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h190, 32'h1122_3344, 4'b0010);
    @(negedge clk);
    check("store_wmask", mem_wmask, 4'b0010);
    next_cycle();
    idle();
    @(negedge clk);
    check("store_no_rvalid", d_rvalid, 1'b0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h190, 32'h0, 4'h0);
    next_cycle();
    idle();
    @(negedge clk);
    check("reload_rdata", d_rdata, 32'h1000_3364);
    next_cycle();

    // Back-to-back fetches 0x0, 0x4, 0x8.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'(4 * k), 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      if (k > 0) check("b2b_rdata", i_rdata, 32'h1000_0000 + 32'(k - 1));
      next_cycle();
    end
    idle();
    @(negedge clk);
    check("b2b_last_rdata", i_rdata, 32'h1000_0002);
    next_cycle();

    // Zero-mask store leaves memory untouched.
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 32'hFFFF_FFFF, 4'b0000);
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
    next_cycle();
    idle();
    @(negedge clk);
    check("zero_mask_rdata", d_rdata, 32'h1000_0002);
    next_cycle();

    // Store granted in the same cycle as a load's rvalid.
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h190, 32'h0, 4'h0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h194, 32'hCAFE_F00D, 4'b1111);
    @(negedge clk);
    check("overlap_rvalid", d_rvalid, 1'b1);
    check("overlap_wgnt", d_gnt, 1'b1);
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h194, 32'h0, 4'h0);
    next_cycle();

    // Fetch contending with a store.
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'hC, 1'b1, 1'b1, 32'h20, 32'hA5A5_5A5A, 4'b1100);
      next_cycle();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    next_cycle();
    idle();
    next_cycle();

    // Reset the cycle after a read grant drops the return.
    drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    next_cycle();
    idle();
    reset = 1'b1;
    @(negedge clk);
    check("reset_drop_rvalid", i_rvalid, 1'b0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_rvalid", i_rvalid, 1'b0);
    next_cycle();
    drive(1'b1, 32'h4, 1'b1, 1'b0, 32'h190, 32'h0, 4'h0);
    @(negedge clk);
    check("post_reset_d_wins", d_gnt, 1'b1);
    next_cycle();
    idle();
    next_cycle();
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
